// File: rtl/tl_master_mo_adapter.sv
// TileLink-UL multi-outstanding master adapter.
// Takes GET/PUTFULL/PUTPARTIAL commands from a small queue and issues them
// on channel A with a free source ID. Channel D beats are matched by source
// and returned in arrival order on the response port.
// Widths and opcodes come from the tl_pkg.vh macros. Fallback values below
// are used when those macros are not already defined.
// Optional feature: define TL_MASTER_TIMEOUT_EN to enable per-slot response
// timeouts of TIMEOUT_CYCLES cycles.

`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 2
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 8
`endif
`ifndef TL_SINK_BITS
`define TL_SINK_BITS 1
`endif
`ifndef TL_A_PUTFULL
`define TL_A_PUTFULL 3'd0
`endif
`ifndef TL_A_PUTPARTIAL
`define TL_A_PUTPARTIAL 3'd1
`endif
`ifndef TL_A_GET
`define TL_A_GET 3'd4
`endif
`ifndef TL_D_ACCESSACK
`define TL_D_ACCESSACK 4'd0
`endif
`ifndef TL_D_ACCESSACKDATA
`define TL_D_ACCESSACKDATA 4'd1
`endif

module tl_master_mo_adapter #(
  parameter int NUM_SRC        = 4,
  parameter int SRC_BASE       = 0,
  parameter int CMD_DEPTH      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  // command queue
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [1:0]                       cmd_type,
  input  logic [`TL_ADDR_BITS-1:0]         cmd_address,
  input  logic [`TL_SIZE_BITS-1:0]         cmd_size,
  input  logic [`TL_DATA_BYTES*8-1:0]      cmd_data,
  input  logic [`TL_DATA_BYTES-1:0]        cmd_mask,
  // channel A
  output logic                             a_valid,
  output logic [2:0]                       a_opcode,
  output logic [2:0]                       a_param,
  output logic [`TL_SIZE_BITS-1:0]         a_size,
  output logic [`TL_SOURCE_BITS-1:0]       a_source,
  output logic [`TL_ADDR_BITS-1:0]         a_address,
  output logic [`TL_DATA_BYTES-1:0]        a_mask,
  output logic [`TL_DATA_BYTES*8-1:0]      a_data,
  input  logic                             a_ready,
  // channel D
  input  logic                             d_valid,
  input  logic [3:0]                       d_opcode,
  input  logic [1:0]                       d_param,
  input  logic [`TL_SIZE_BITS-1:0]         d_size,
  input  logic [`TL_SOURCE_BITS-1:0]       d_source,
  input  logic [`TL_SINK_BITS-1:0]         d_sink,
  input  logic                             d_denied,
  input  logic [`TL_DATA_BYTES*8-1:0]      d_data,
  output logic                             d_ready,
  // response port
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [`TL_SOURCE_BITS-1:0]       rsp_source,
  output logic [`TL_DATA_BYTES*8-1:0]      rsp_data,
  output logic                             rsp_denied,
  output logic                             rsp_error,
  output logic [$clog2(NUM_SRC+1)-1:0]     outstanding,
  output logic                             idle
);

  localparam int AW     = `TL_ADDR_BITS;
  localparam int DB     = `TL_DATA_BYTES;
  localparam int DW     = `TL_DATA_BYTES * 8;
  localparam int SZW    = `TL_SIZE_BITS;
  localparam int SRCW   = `TL_SOURCE_BITS;
  localparam int SLOT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W  = $clog2(CMD_DEPTH + 1);
  localparam int OUT_W  = $clog2(NUM_SRC + 1);

  // ---------------- command queue ----------------
  logic [1:0]       q_type_mem [CMD_DEPTH];
  logic [AW-1:0]    q_addr_mem [CMD_DEPTH];
  logic [SZW-1:0]   q_size_mem [CMD_DEPTH];
  logic [DW-1:0]    q_data_mem [CMD_DEPTH];
  logic [DB-1:0]    q_mask_mem [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic             q_empty, q_full, push, pop;

  logic [1:0]       head_type;
  logic [AW-1:0]    head_addr;
  logic [SZW-1:0]   head_size;
  logic [DW-1:0]    head_data;
  logic [DB-1:0]    head_mask;

  assign q_empty   = (q_cnt_q == '0);
  assign q_full    = (q_cnt_q == CNT_W'(CMD_DEPTH));
  assign cmd_ready = !q_full;
  assign push      = cmd_valid && !q_full;

  assign head_type = q_type_mem[rd_ptr_q];
  assign head_addr = q_addr_mem[rd_ptr_q];
  assign head_size = q_size_mem[rd_ptr_q];
  assign head_data = q_data_mem[rd_ptr_q];
  assign head_mask = q_mask_mem[rd_ptr_q];

  // Queue storage carries no reset: occupancy is tracked by q_cnt_q alone
  always_ff @(posedge clk) begin
    if (push) begin
      q_type_mem[wr_ptr_q] <= cmd_type;
      q_addr_mem[wr_ptr_q] <= cmd_address;
      q_size_mem[wr_ptr_q] <= cmd_size;
      q_data_mem[wr_ptr_q] <= cmd_data;
      q_mask_mem[wr_ptr_q] <= cmd_mask;
    end
  end

  // Queue pointer and occupancy update; pointers wrap naturally (power-of-two depth)
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    q_cnt_d  = q_cnt_q + CNT_W'(push) - CNT_W'(pop);
  end

  // ---------------- slot tracking ----------------
  logic [NUM_SRC-1:0] busy_q, busy_d;
  logic [NUM_SRC-1:0] slot_get_q, slot_get_d;
  logic [SLOT_W-1:0]  free_idx;
  logic               any_free;
  logic               a_load;

  // Lowest-index free slot, taken from the registered busy vector so a slot
  // freed this cycle only becomes allocatable next cycle
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        any_free = 1'b1;
        free_idx = SLOT_W'(i);
      end
    end
  end

  // ---------------- channel A register ----------------
  logic             a_valid_q, a_valid_d;
  logic [2:0]       a_opcode_q, a_opcode_d;
  logic [SZW-1:0]   a_size_q, a_size_d;
  logic [SRCW-1:0]  a_source_q, a_source_d;
  logic [AW-1:0]    a_address_q, a_address_d;
  logic [DB-1:0]    a_mask_q, a_mask_d;
  logic [DW-1:0]    a_data_q, a_data_d;
  logic             head_is_get;

  assign a_load      = (!a_valid_q || a_ready) && !q_empty && any_free;
  assign pop         = a_load;
  assign head_is_get = (head_type == 2'd0) || (head_type == 2'd3);

  // A stage: load the queue head into a free slot, otherwise hold while stalled
  always_comb begin
    a_valid_d   = a_valid_q;
    a_opcode_d  = a_opcode_q;
    a_size_d    = a_size_q;
    a_source_d  = a_source_q;
    a_address_d = a_address_q;
    a_mask_d    = a_mask_q;
    a_data_d    = a_data_q;
    if (a_load) begin
      a_valid_d   = 1'b1;
      a_size_d    = head_size;
      a_source_d  = SRCW'(SRC_BASE) + SRCW'(free_idx);
      a_address_d = head_addr;
      a_data_d    = head_data;
      a_mask_d    = '1;
      case (head_type)
        2'd1:    a_opcode_d = `TL_A_PUTFULL;
        2'd2: begin
          a_opcode_d = `TL_A_PUTPARTIAL;
          a_mask_d   = head_mask;
        end
        default: a_opcode_d = `TL_A_GET;
      endcase
    end else if (a_ready) begin
      a_valid_d = 1'b0;
    end
  end

  assign a_valid   = a_valid_q;
  assign a_opcode  = a_opcode_q;
  assign a_param   = 3'd0;
  assign a_size    = a_size_q;
  assign a_source  = a_source_q;
  assign a_address = a_address_q;
  assign a_mask    = a_mask_q;
  assign a_data    = a_data_q;

  // ---------------- channel D decode ----------------
  logic              rsp_valid_q, rsp_valid_d;
  logic [SRCW-1:0]   rsp_source_q, rsp_source_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;
  logic              rsp_denied_q, rsp_denied_d;
  logic              rsp_error_q, rsp_error_d;
  logic              d_fire, d_in_range, d_hit, d_get, d_opc_ok, d_free;
  logic [SLOT_W-1:0] d_idx;
  int                d_off;
  logic              to_report;
  logic [SLOT_W-1:0] to_idx;
  logic              unused_d;

  assign unused_d = ^{d_param, d_size, d_sink};
  assign d_ready  = !rsp_valid_q || rsp_ready;
  assign d_fire   = d_valid && d_ready;

  // Map d_source onto a slot and classify the beat
  always_comb begin
    d_off      = int'(d_source) - SRC_BASE;
    d_in_range = (d_off >= 0) && (d_off < NUM_SRC);
    d_idx      = SLOT_W'(d_off);
    d_hit      = d_in_range && busy_q[d_idx];
    d_get      = d_hit && slot_get_q[d_idx];
    d_opc_ok   = d_get ? (d_opcode == `TL_D_ACCESSACKDATA)
                       : (d_opcode == `TL_D_ACCESSACK);
    d_free     = d_fire && d_hit;
  end

  // ---------------- optional response timeout ----------------
`ifdef TL_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [NUM_SRC-1:0] to_expired;
  logic [NUM_SRC-1:0] alloc_vec;
  logic               any_expired;

  // One-hot of the slot being allocated this cycle
  always_comb begin
    alloc_vec = '0;
    if (a_load) alloc_vec[free_idx] = 1'b1;
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_timeout
    logic [TO_W-1:0] cnt_q, cnt_d;

    // Per-slot age counter, saturating at the expiry point
    always_comb begin
      cnt_d = cnt_q;
      if (alloc_vec[gi]) cnt_d = '0;
      else if (busy_q[gi] && (cnt_q != TO_W'(TIMEOUT_CYCLES - 1))) cnt_d = cnt_q + 1'b1;
    end

    // Age counter register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
    end

    assign to_expired[gi] = busy_q[gi] && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  end

  // Lowest expired slot wins; D beats always take precedence
  always_comb begin
    any_expired = 1'b0;
    to_idx      = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (to_expired[i]) begin
        any_expired = 1'b1;
        to_idx      = SLOT_W'(i);
      end
    end
  end

  assign to_report = !d_fire && (!rsp_valid_q || rsp_ready) && any_expired;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign to_report = 1'b0;
  assign to_idx    = '0;
`endif

  // Slot busy/type bookkeeping: free on D hit or timeout report, mark on A load
  always_comb begin
    busy_d     = busy_q;
    slot_get_d = slot_get_q;
    if (d_free)    busy_d[d_idx]  = 1'b0;
    if (to_report) busy_d[to_idx] = 1'b0;
    if (a_load) begin
      busy_d[free_idx]     = 1'b1;
      slot_get_d[free_idx] = head_is_get;
    end
  end

  // Response register: hold until accepted, load from D or a timeout report
  always_comb begin
    rsp_valid_d  = rsp_valid_q && !rsp_ready;
    rsp_source_d = rsp_source_q;
    rsp_data_d   = rsp_data_q;
    rsp_denied_d = rsp_denied_q;
    rsp_error_d  = rsp_error_q;
    if (d_fire) begin
      rsp_valid_d  = 1'b1;
      rsp_source_d = d_source;
      rsp_data_d   = d_get ? d_data : '0;
      rsp_denied_d = d_denied;
      rsp_error_d  = !d_hit || !d_opc_ok;
    end else if (to_report) begin
      rsp_valid_d  = 1'b1;
      rsp_source_d = SRCW'(SRC_BASE) + SRCW'(to_idx);
      rsp_data_d   = '0;
      rsp_denied_d = 1'b0;
      rsp_error_d  = 1'b1;
    end
  end

  logic [OUT_W-1:0] out_q, out_d;

  // Busy-slot count: +1 on A load, -1 on any slot free
  always_comb begin
    out_d = out_q + OUT_W'(a_load) - OUT_W'(d_free || to_report);
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      q_cnt_q      <= '0;
      busy_q       <= '0;
      slot_get_q   <= '0;
      a_valid_q    <= 1'b0;
      a_opcode_q   <= '0;
      a_size_q     <= '0;
      a_source_q   <= '0;
      a_address_q  <= '0;
      a_mask_q     <= '0;
      a_data_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_source_q <= '0;
      rsp_data_q   <= '0;
      rsp_denied_q <= 1'b0;
      rsp_error_q  <= 1'b0;
      out_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      q_cnt_q      <= q_cnt_d;
      busy_q       <= busy_d;
      slot_get_q   <= slot_get_d;
      a_valid_q    <= a_valid_d;
      a_opcode_q   <= a_opcode_d;
      a_size_q     <= a_size_d;
      a_source_q   <= a_source_d;
      a_address_q  <= a_address_d;
      a_mask_q     <= a_mask_d;
      a_data_q     <= a_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_source_q <= rsp_source_d;
      rsp_data_q   <= rsp_data_d;
      rsp_denied_q <= rsp_denied_d;
      rsp_error_q  <= rsp_error_d;
      out_q        <= out_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_source  = rsp_source_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_denied  = rsp_denied_q;
  assign rsp_error   = rsp_error_q;
  assign outstanding = out_q;
  assign idle        = q_empty && (busy_q == '0) && !a_valid_q && !rsp_valid_q;

endmodule

// File: tb/tb_tl_master_mo_adapter.sv
// Directed testbench for tl_master_mo_adapter with A-channel and response
// scoreboards. Timeout checks are included when TL_MASTER_TIMEOUT_EN is set.

`ifndef TL_ADDR_BITS
`define TL_ADDR_BITS 32
`endif
`ifndef TL_DATA_BYTES
`define TL_DATA_BYTES 4
`endif
`ifndef TL_SIZE_BITS
`define TL_SIZE_BITS 2
`endif
`ifndef TL_SOURCE_BITS
`define TL_SOURCE_BITS 8
`endif
`ifndef TL_SINK_BITS
`define TL_SINK_BITS 1
`endif

module tb_tl_master_mo_adapter;
  localparam int AW   = `TL_ADDR_BITS;
  localparam int DB   = `TL_DATA_BYTES;
  localparam int DW   = `TL_DATA_BYTES * 8;
  localparam int SZW  = `TL_SIZE_BITS;
  localparam int SRCW = `TL_SOURCE_BITS;
  localparam int SNKW = `TL_SINK_BITS;

  localparam logic [2:0] A_PUTFULL    = 3'd0;
  localparam logic [2:0] A_PUTPARTIAL = 3'd1;
  localparam logic [2:0] A_GET        = 3'd4;
  localparam logic [3:0] D_ACK        = 4'd0;
  localparam logic [3:0] D_ACKDATA    = 4'd1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cmd_valid = 1'b0, cmd_ready;
  logic [1:0]      cmd_type = '0;
  logic [AW-1:0]   cmd_address = '0;
  logic [SZW-1:0]  cmd_size = '0;
  logic [DW-1:0]   cmd_data = '0;
  logic [DB-1:0]   cmd_mask = '0;
  logic            a_valid;
  logic [2:0]      a_opcode, a_param;
  logic [SZW-1:0]  a_size;
  logic [SRCW-1:0] a_source;
  logic [AW-1:0]   a_address;
  logic [DB-1:0]   a_mask;
  logic [DW-1:0]   a_data;
  logic            a_ready = 1'b1;
  logic            d_valid = 1'b0;
  logic [3:0]      d_opcode = '0;
  logic [1:0]      d_param = '0;
  logic [SZW-1:0]  d_size = '0;
  logic [SRCW-1:0] d_source = '0;
  logic [SNKW-1:0] d_sink = '0;
  logic            d_denied = 1'b0;
  logic [DW-1:0]   d_data = '0;
  logic            d_ready;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [SRCW-1:0] rsp_source;
  logic [DW-1:0]   rsp_data;
  logic            rsp_denied, rsp_error;
  logic [2:0]      outstanding;
  logic            idle;

  tl_master_mo_adapter #(
    .NUM_SRC(4), .SRC_BASE(0), .CMD_DEPTH(2), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_address(cmd_address), .cmd_size(cmd_size), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .a_valid(a_valid), .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size),
    .a_source(a_source), .a_address(a_address), .a_mask(a_mask), .a_data(a_data),
    .a_ready(a_ready),
    .d_valid(d_valid), .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size),
    .d_source(d_source), .d_sink(d_sink), .d_denied(d_denied), .d_data(d_data),
    .d_ready(d_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_source(rsp_source),
    .rsp_data(rsp_data), .rsp_denied(rsp_denied), .rsp_error(rsp_error),
    .outstanding(outstanding), .idle(idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]      opcode;
    logic [SRCW-1:0] source;
    logic [AW-1:0]   address;
    logic [DB-1:0]   mask;
    logic [DW-1:0]   data;
  } a_exp_t;

  typedef struct {
    logic [SRCW-1:0] source;
    logic [DW-1:0]   data;
    logic            denied;
    logic            error;
  } r_exp_t;

  a_exp_t a_q[$];
  r_exp_t r_q[$];
  a_exp_t ea;
  r_exp_t er;
  int     n_tests = 0;
  int     n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input logic [2:0] opc, input logic [SRCW-1:0] src,
                       input logic [AW-1:0] addr, input logic [DB-1:0] mask,
                       input logic [DW-1:0] data);
    a_exp_t e;
    e.opcode = opc; e.source = src; e.address = addr; e.mask = mask; e.data = data;
    a_q.push_back(e);
  endtask

  task automatic push_cmd(input logic [1:0] t, input logic [AW-1:0] addr,
                          input logic [DW-1:0] data, input logic [DB-1:0] mask);
    int n = 0;
    cmd_valid = 1'b1; cmd_type = t; cmd_address = addr; cmd_size = 2'd2;
    cmd_data = data; cmd_mask = mask;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_d(input logic [SRCW-1:0] src, input logic [3:0] opc,
                        input logic [DW-1:0] data, input logic den,
                        input logic [DW-1:0] exp_data, input logic exp_err);
    r_exp_t e;
    int n = 0;
    d_valid = 1'b1; d_source = src; d_opcode = opc; d_data = data; d_denied = den;
    while (!d_ready && n < 100) begin tick(); n++; end
    if (n >= 100) check("d_ready_timeout", 64'(d_ready), 64'd1);
    e.source = src; e.data = exp_data; e.denied = den; e.error = exp_err;
    r_q.push_back(e);
    tick();
    d_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((a_q.size() != 0 || r_q.size() != 0) && n < 300) begin tick(); n++; end
    check({tag, "_drain"}, 64'(a_q.size() + r_q.size()), 64'd0);
  endtask

  // A-channel scoreboard: every accepted A beat must match the next expectation
  always @(negedge clk) begin
    if (!rst && a_valid && a_ready) begin
      if (a_q.size() == 0) begin
        check("a_unexpected_beat", 64'(a_q.size()), 64'd1);
      end else begin
        ea = a_q.pop_front();
        check("a_opcode", 64'(a_opcode), 64'(ea.opcode));
        check("a_source", 64'(a_source), 64'(ea.source));
        check("a_address", 64'(a_address), 64'(ea.address));
        check("a_mask", 64'(a_mask), 64'(ea.mask));
        check("a_data", 64'(a_data), 64'(ea.data));
        check("a_param", 64'(a_param), 64'd0);
      end
    end
  end

  // Response scoreboard: every accepted response must match in arrival order
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (r_q.size() == 0) begin
        check("rsp_unexpected", 64'(r_q.size()), 64'd1);
      end else begin
        er = r_q.pop_front();
        check("rsp_source", 64'(rsp_source), 64'(er.source));
        check("rsp_data", 64'(rsp_data), 64'(er.data));
        check("rsp_denied", 64'(rsp_denied), 64'(er.denied));
        check("rsp_error", 64'(rsp_error), 64'(er.error));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  seen;
    // ---- reset state ----
    tick(); tick();
    check("rst_a_valid", 64'(a_valid), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_outstanding", 64'(outstanding), 64'd0);
    check("rst_rsp_error", 64'(rsp_error), 64'd0);
    rst = 1'b0;
    tick();

    // ---- single GET ----
    exp_a(A_GET, 8'd0, 32'h100, 4'hF, 32'h0);
    push_cmd(2'd0, 32'h100, 32'h0, 4'h0);
    wait_drain("get1_a");
    check("get1_outstanding_busy", 64'(outstanding), 64'd1);
    check("get1_not_idle", 64'(idle), 64'd0);
    send_d(8'd0, D_ACKDATA, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    wait_drain("get1_rsp");
    check("get1_outstanding_done", 64'(outstanding), 64'd0);
    check("get1_idle", 64'(idle), 64'd1);

    // ---- four PUTFULLs fill every slot, fifth waits ----
    for (int i = 0; i < 4; i++) begin
      exp_a(A_PUTFULL, 8'(i), 32'h200 + 32'(4 * i), 4'hF, 32'(i + 1));
      push_cmd(2'd1, 32'h200 + 32'(4 * i), 32'(i + 1), 4'h0);
    end
    push_cmd(2'd1, 32'h300, 32'h55, 4'h0);
    wait_drain("put4_a");
    tick(); tick(); tick();
    check("put5_stalled_a_valid", 64'(a_valid), 64'd0);
    check("put4_outstanding_full", 64'(outstanding), 64'd4);
    check("put5_cmd_ready", 64'(cmd_ready), 64'd1);
    exp_a(A_PUTFULL, 8'd2, 32'h300, 4'hF, 32'h55);
    send_d(8'd2, D_ACK, 32'h0, 1'b0, 32'h0, 1'b0);
    wait_drain("put5_a");
    check("put5_outstanding", 64'(outstanding), 64'd4);
    for (int i = 0; i < 4; i++) send_d(8'(i), D_ACK, 32'hFFFF, 1'b0, 32'h0, 1'b0);
    wait_drain("put_all_rsp");
    check("put_outstanding_done", 64'(outstanding), 64'd0);

    // ---- out-of-order GET responses ----
    exp_a(A_GET, 8'd0, 32'h400, 4'hF, 32'h0);
    push_cmd(2'd0, 32'h400, 32'h0, 4'h0);
    exp_a(A_GET, 8'd1, 32'h404, 4'hF, 32'h0);
    push_cmd(2'd3, 32'h404, 32'h0, 4'h0);
    wait_drain("ooo_a");
    send_d(8'd1, D_ACKDATA, 32'h11111111, 1'b0, 32'h11111111, 1'b0);
    send_d(8'd0, D_ACKDATA, 32'h22222222, 1'b1, 32'h22222222, 1'b0);
    wait_drain("ooo_rsp");
    check("ooo_outstanding", 64'(outstanding), 64'd0);

    // ---- PUTPARTIAL answered with the wrong opcode ----
    exp_a(A_PUTPARTIAL, 8'd0, 32'h500, 4'h3, 32'hAABBCCDD);
    push_cmd(2'd2, 32'h500, 32'hAABBCCDD, 4'h3);
    wait_drain("pp_a");
    check("pp_outstanding_busy", 64'(outstanding), 64'd1);
    send_d(8'd0, D_ACKDATA, 32'h55, 1'b0, 32'h0, 1'b1);
    wait_drain("pp_rsp");
    check("pp_outstanding_freed", 64'(outstanding), 64'd0);

    // ---- A stall while D frees a lower slot ----
    exp_a(A_GET, 8'd0, 32'h600, 4'hF, 32'h0);
    push_cmd(2'd0, 32'h600, 32'h0, 4'h0);
    wait_drain("stall_pre");
    a_ready = 1'b0;
    push_cmd(2'd0, 32'h604, 32'h0, 4'h0);
    tick();
    check("stall_a_valid", 64'(a_valid), 64'd1);
    send_d(8'd0, D_ACKDATA, 32'h77, 1'b0, 32'h77, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("stall_hold_source", 64'(a_source), 64'd1);
      check("stall_hold_addr", 64'(a_address), 64'h604);
      check("stall_hold_valid", 64'(a_valid), 64'd1);
      tick();
    end
    exp_a(A_GET, 8'd1, 32'h604, 4'hF, 32'h0);
    a_ready = 1'b1;
    wait_drain("stall_release");
    check("stall_outstanding", 64'(outstanding), 64'd1);

    // ---- D on an unused source ----
    send_d(8'd3, D_ACKDATA, 32'h9, 1'b0, 32'h0, 1'b1);
    wait_drain("unused_src");
    check("unused_src_outstanding", 64'(outstanding), 64'd1);

    // ---- response backpressure ----
    rsp_ready = 1'b0;
    send_d(8'd1, D_ACKDATA, 32'hABCD, 1'b0, 32'hABCD, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      check("bp_d_ready", 64'(d_ready), 64'd0);
      check("bp_rsp_data", 64'(rsp_data), 64'hABCD);
      tick();
    end
    rsp_ready = 1'b1;
    wait_drain("bp");
    check("bp_outstanding", 64'(outstanding), 64'd0);
    check("bp_idle", 64'(idle), 64'd1);

`ifdef TL_MASTER_TIMEOUT_EN
    // ---- timeout of an unanswered GET ----
    begin
      r_exp_t e;
      exp_a(A_GET, 8'd0, 32'h700, 4'hF, 32'h0);
      push_cmd(2'd0, 32'h700, 32'h0, 4'h0);
      n = 0;
      while (!a_valid && n < 20) begin tick(); n++; end
      e.source = 8'd0; e.data = 32'h0; e.denied = 1'b0; e.error = 1'b1;
      r_q.push_back(e);
      n = 0;
      while (!rsp_valid && n < 100) begin tick(); n++; end
      check("timeout_latency", 64'(n), 64'd16);
      wait_drain("timeout");
      check("timeout_outstanding", 64'(outstanding), 64'd0);
      send_d(8'd0, D_ACKDATA, 32'h1234, 1'b0, 32'h0, 1'b1);
      wait_drain("late_d");
    end
`endif

    // ---- reset mid-transaction ----
    exp_a(A_GET, 8'd0, 32'h800, 4'hF, 32'h0);
    push_cmd(2'd0, 32'h800, 32'h0, 4'h0);
    wait_drain("midrst_a");
    check("midrst_outstanding_before", 64'(outstanding), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_idle", 64'(idle), 64'd1);
    check("midrst_outstanding", 64'(outstanding), 64'd0);
    tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      seen = seen | rsp_valid;
      tick();
    end
    check("midrst_no_rsp", 64'(seen), 64'd0);
    check("midrst_idle_after", 64'(idle), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
